// File: rtl/riscv_dm_pkg.sv
// riscv_dm_pkg: DMI field widths, op/response encodings and arbiter state type
package riscv_dm_pkg;
   localparam int DMI_ADDR_WIDTH = 7;
   localparam int DMI_DATA_WIDTH = 32;
   localparam int DMI_OP_WIDTH   = 2;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_NOP       = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_READ      = 2'd1;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_WRITE     = 2'd2;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_RESP_SUCCESS = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_RESP_FAILED  = 2'd2;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_RESP_BUSY    = 2'd3;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESP} dmi_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from the pointer with wrap
module rr_arbiter #(
   parameter  int NUM_REQ    = 2,
   localparam int OWNER_BITS = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]    i_req,
   input  logic [OWNER_BITS-1:0] i_ptr,
   output logic [NUM_REQ-1:0]    o_gnt,
   output logic [OWNER_BITS-1:0] o_idx,
   output logic                  o_valid
);
   function automatic logic [OWNER_BITS-1:0] wrap(input int v);
      return OWNER_BITS'(v % NUM_REQ);
   endfunction
   // scan from farthest to nearest so the requester closest to the pointer wins last
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[wrap(int'(i_ptr) + i)]) begin
            o_idx   = wrap(int'(i_ptr) + i);
            o_gnt   = NUM_REQ'(1) << wrap(int'(i_ptr) + i);
            o_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin sharing of one DMI port with response routing and timeout drain
module dmi_arbiter import riscv_dm_pkg::*; #(
   parameter  int NUM_REQ        = 2,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int OWNER_BITS     = $clog2(NUM_REQ),
   localparam int CNT_BITS       = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [NUM_REQ-1:0]                       req_valid_i,
   output logic [NUM_REQ-1:0]                       req_ready_o,
   input  logic [NUM_REQ-1:0][DMI_ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [NUM_REQ-1:0][DMI_DATA_WIDTH-1:0]   req_data_i,
   input  logic [NUM_REQ-1:0][DMI_OP_WIDTH-1:0]     req_op_i,
   output logic [NUM_REQ-1:0]                       resp_valid_o,
   input  logic [NUM_REQ-1:0]                       resp_ready_i,
   output logic [NUM_REQ-1:0][DMI_DATA_WIDTH-1:0]   resp_data_o,
   output logic [NUM_REQ-1:0][DMI_OP_WIDTH-1:0]     resp_op_o,
   output logic                                     dm_req_valid_o,
   input  logic                                     dm_req_ready_i,
   output logic [DMI_ADDR_WIDTH-1:0]                dm_req_addr_o,
   output logic [DMI_DATA_WIDTH-1:0]                dm_req_data_o,
   output logic [DMI_OP_WIDTH-1:0]                  dm_req_op_o,
   input  logic                                     dm_resp_valid_i,
   output logic                                     dm_resp_ready_o,
   input  logic [DMI_DATA_WIDTH-1:0]                dm_resp_data_i,
   input  logic [DMI_OP_WIDTH-1:0]                  dm_resp_op_i,
   output logic [OWNER_BITS-1:0]                    owner_o,
   output logic                                     busy_o,
   output logic                                     timeout_o
);
   localparam int CNT_W = (CNT_BITS > 0) ? CNT_BITS : 1;
   dmi_arb_state_t r_state, w_next;
   logic [OWNER_BITS-1:0]     r_owner, r_ptr, w_idx;
   logic [NUM_REQ-1:0]        w_gnt;
   logic                      w_any, w_grant, w_expire, r_drain, r_timeout;
   logic [CNT_W-1:0]          r_cnt;
   logic [DMI_ADDR_WIDTH-1:0] r_addr;
   logic [DMI_DATA_WIDTH-1:0] r_wdata, r_rdata;
   logic [DMI_OP_WIDTH-1:0]   r_op, r_rop;
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .i_req   (req_valid_i),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_valid (w_any)
   );
   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // next state, grant/expiry decisions and handshake outputs
   always_comb begin
      w_grant  = (r_state == IDLE) && !r_drain && w_any;
      w_expire = (TIMEOUT_CYCLES > 0) && (r_state == WAIT_RESP) && !dm_resp_valid_i &&
                 (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
      case (r_state)
         IDLE:      w_next = w_grant ? ISSUE : IDLE;
         ISSUE:     w_next = dm_req_ready_i ? WAIT_RESP : ISSUE;
         WAIT_RESP: w_next = (dm_resp_valid_i || w_expire) ? RESP : WAIT_RESP;
         RESP:      w_next = resp_ready_i[r_owner] ? IDLE : RESP;
         default:   w_next = IDLE;
      endcase
      req_ready_o     = w_grant ? w_gnt : '0;
      dm_req_valid_o  = r_state == ISSUE;
      dm_resp_ready_o = (r_state == WAIT_RESP) || r_drain;
      resp_valid_o    = (r_state == RESP) ? NUM_REQ'(1) << r_owner : '0;
   end
   assign resp_data_o   = {NUM_REQ{r_rdata}};
   assign resp_op_o     = {NUM_REQ{r_rop}};
   assign dm_req_addr_o = r_addr;
   assign dm_req_data_o = r_wdata;
   assign dm_req_op_o   = r_op;
   assign owner_o       = r_owner;
   assign busy_o        = (r_state != IDLE) || r_drain;
   assign timeout_o     = r_timeout;
   // request capture, pointer, timeout counter, response capture and drain tracking
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_owner   <= '0;
         r_ptr     <= '0;
         r_drain   <= 1'b0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_op      <= '0;
         r_rdata   <= '0;
         r_rop     <= '0;
      end else begin
         r_timeout <= w_expire;
         if (w_expire) r_drain <= 1'b1;
         else if (r_drain && dm_resp_valid_i) r_drain <= 1'b0;
         if (w_grant) begin
            r_addr  <= req_addr_i[w_idx];
            r_wdata <= req_data_i[w_idx];
            r_op    <= req_op_i[w_idx];
            r_owner <= w_idx;
            r_ptr   <= (w_idx == OWNER_BITS'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
         end
         if (r_state == ISSUE && dm_req_ready_i) r_cnt <= '0;
         else if (r_state == WAIT_RESP && TIMEOUT_CYCLES > 0) r_cnt <= r_cnt + 1'b1;
         if (r_state == WAIT_RESP && dm_resp_valid_i) begin
            r_rdata <= dm_resp_data_i;
            r_rop   <= dm_resp_op_i;
         end else if (w_expire) begin
            r_rdata <= '0;
            r_rop   <= DMI_RESP_FAILED;
         end
      end
   end
endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: directed checks of grant order, routing, back-pressure, timeout/drain and reset
module tb_dmi_arbiter;
   import riscv_dm_pkg::*;
   localparam int N = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [N-1:0]                     req_valid, req_ready, resp_valid, resp_ready;
   logic [N-1:0][DMI_ADDR_WIDTH-1:0] req_addr;
   logic [N-1:0][DMI_DATA_WIDTH-1:0] req_data, resp_data;
   logic [N-1:0][DMI_OP_WIDTH-1:0]   req_op, resp_op;
   logic                             dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready;
   logic [DMI_ADDR_WIDTH-1:0]        dm_req_addr;
   logic [DMI_DATA_WIDTH-1:0]        dm_req_data, dm_resp_data;
   logic [DMI_OP_WIDTH-1:0]          dm_req_op, dm_resp_op;
   logic [0:0]                       owner;
   logic                             busy, timeout;
   int passed = 0;
   int total = 0;
   dmi_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_data_i(req_data), .req_op_i(req_op),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_data_o(resp_data), .resp_op_o(resp_op),
      .dm_req_valid_o(dm_req_valid), .dm_req_ready_i(dm_req_ready),
      .dm_req_addr_o(dm_req_addr), .dm_req_data_o(dm_req_data), .dm_req_op_o(dm_req_op),
      .dm_resp_valid_i(dm_resp_valid), .dm_resp_ready_o(dm_resp_ready),
      .dm_resp_data_i(dm_resp_data), .dm_resp_op_i(dm_resp_op),
      .owner_o(owner), .busy_o(busy), .timeout_o(timeout)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic half();
      @(negedge clk);
   endtask
   initial begin
      req_valid = '0; req_addr = '0; req_data = '0; req_op = '0; resp_ready = '0;
      dm_req_ready = 1'b1; dm_resp_valid = 1'b0; dm_resp_data = '0; dm_resp_op = '0;
      repeat (2) nxt();
      rst = 1'b0;
      half();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_dm_req_valid", dm_req_valid, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_outs", {owner, busy, timeout, dm_resp_ready}, 0);
      chk("rst_dm_fields", {dm_req_addr, dm_req_data, dm_req_op}, 0);
      // single requester 0 read of 0x11
      nxt();
      req_valid = 2'b01; req_addr[0] = 7'h11; req_op[0] = DMI_OP_READ;
      half();
      chk("s1_req_ready", req_ready, 2'b01);
      nxt();
      req_valid = '0;
      half();
      chk("s1_dm_req_valid", dm_req_valid, 1);
      chk("s1_dm_req_addr", dm_req_addr, 7'h11);
      chk("s1_dm_req_op", dm_req_op, DMI_OP_READ);
      chk("s1_busy", busy, 1);
      nxt();
      half();
      chk("s1_wait", {dm_resp_ready, dm_req_valid}, 2'b10);
      dm_resp_valid = 1'b1; dm_resp_data = 32'hDEADBEEF; dm_resp_op = DMI_RESP_SUCCESS;
      nxt();
      dm_resp_valid = 1'b0;
      half();
      chk("s1_resp_valid", resp_valid, 2'b01);
      chk("s1_resp_data", resp_data[0], 32'hDEADBEEF);
      chk("s1_resp_op", resp_op[0], DMI_RESP_SUCCESS);
      resp_ready = 2'b11;
      nxt();
      half();
      chk("s1_done", {resp_valid, busy}, 0);
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      // both requesters continuously valid: grants alternate 0,1,0,1
      req_valid = 2'b11;
      req_addr[0] = 7'h20; req_addr[1] = 7'h21;
      req_op[0] = DMI_OP_READ; req_op[1] = DMI_OP_WRITE; req_data[1] = 32'hCAFE0001;
      for (int k = 0; k < 4; k++) begin
         half();
         chk("s2_req_ready", req_ready, 2'b01 << (k & 1));
         nxt();
         half();
         chk("s2_owner", owner, k & 1);
         chk("s2_dm_req_addr", dm_req_addr, 7'h20 + (k & 1));
         nxt();
         dm_resp_valid = 1'b1; dm_resp_data = 32'hA000 + k;
         nxt();
         dm_resp_valid = 1'b0;
         half();
         chk("s2_resp_valid", resp_valid, 2'b01 << (k & 1));
         chk("s2_resp_data", resp_data[k & 1], 32'hA000 + k);
         nxt();
      end
      // DM back-pressure for 50 cycles
      dm_req_ready = 1'b0; req_addr[0] = 7'h33;
      half();
      chk("s3_req_ready", req_ready, 2'b01);
      nxt();
      req_valid = '0;
      for (int i = 0; i < 50; i++) begin
         half();
         chk("s3_hold", {dm_req_valid, dm_req_addr, req_ready, timeout}, {1'b1, 7'h33, 2'b00, 1'b0});
         nxt();
      end
      dm_req_ready = 1'b1;
      nxt();
      // DM never responds: timeout after 8 cycles in WAIT_RESP
      for (int i = 0; i < 8; i++) begin
         half();
         chk("s4_no_timeout_yet", {timeout, dm_resp_ready}, 2'b01);
         nxt();
      end
      half();
      chk("s4_timeout", timeout, 1);
      chk("s4_resp_valid", resp_valid, 2'b01);
      chk("s4_resp_op", resp_op[0], DMI_RESP_FAILED);
      chk("s4_resp_data", resp_data[0], 0);
      chk("s4_busy", busy, 1);
      req_valid = 2'b10; req_addr[1] = 7'h44;
      nxt();
      half();
      chk("s4_drain", {timeout, busy, req_ready, dm_resp_ready}, 5'b01001);
      nxt();
      half();
      chk("s4_drain_nogrant", req_ready, 0);
      dm_resp_valid = 1'b1; dm_resp_data = 32'h5555;
      nxt();
      dm_resp_valid = 1'b0;
      half();
      chk("s4_busy_fall", busy, 0);
      chk("s4_regrant", req_ready, 2'b10);
      nxt();
      half();
      chk("s4_owner", owner, 1);
      chk("s4_dm_req_addr", dm_req_addr, 7'h44);
      req_valid = '0;
      nxt();
      // response arrives exactly in the expiry cycle
      repeat (7) nxt();
      dm_resp_valid = 1'b1; dm_resp_data = 32'h77; dm_resp_op = DMI_RESP_SUCCESS;
      nxt();
      dm_resp_valid = 1'b0;
      half();
      chk("s5_no_timeout", timeout, 0);
      chk("s5_resp_valid", resp_valid, 2'b10);
      chk("s5_resp_data", resp_data[1], 32'h77);
      chk("s5_resp_op", resp_op[1], DMI_RESP_SUCCESS);
      nxt();
      // reset during WAIT_RESP
      req_valid = 2'b01; req_addr[0] = 7'h55;
      nxt();
      req_valid = '0;
      nxt();
      half();
      chk("s6_in_wait", dm_resp_ready, 1);
      rst = 1'b1;
      nxt();
      half();
      chk("s6_rst_outs", {busy, dm_resp_ready, dm_req_valid, owner, timeout}, 0);
      chk("s6_rst_resp", resp_valid, 0);
      chk("s6_rst_addr", dm_req_addr, 0);
      rst = 1'b0; req_valid = 2'b11;
      #1;
      chk("s6_grant0", req_ready, 2'b01);
      nxt();
      req_valid = '0;
      half();
      chk("s6_owner", owner, 0);
      chk("s6_dm_req_addr", dm_req_addr, 7'h55);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
